// File: rtl/rf_write_sched_if.sv
// Bundle of writeback, mul/div, decode and register-file write signals around rf_write_sched.
// Forwarding signals exist only when RF_SCHED_BYPASS_EN is defined.
interface rf_write_sched_if;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [63:0] wb_wdata_i;
    logic        wb_stall_o;
    logic        md_issue_i;
    logic [4:0]  md_issue_rd_i;
    logic        md_valid_i;
    logic [4:0]  md_rd_i;
    logic [63:0] md_wdata_i;
    logic        md_ready_o;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic [4:0]  id_rd_i;
    logic        id_stall_o;
    logic        rf_wen_o;
    logic [4:0]  rf_rd_o;
    logic [63:0] rf_wdata_o;
    logic [31:0] busy_o;
`ifdef RF_SCHED_BYPASS_EN
    logic        fwd1_valid_o;
    logic        fwd2_valid_o;
    logic [63:0] fwd_data_o;
`endif

    modport master (
        output wb_valid_i, wb_rd_i, wb_wdata_i,
        output md_issue_i, md_issue_rd_i, md_valid_i, md_rd_i, md_wdata_i,
        output id_rs1_i, id_rs2_i, id_rd_i,
`ifdef RF_SCHED_BYPASS_EN
        input  fwd1_valid_o, fwd2_valid_o, fwd_data_o,
`endif
        input  wb_stall_o, md_ready_o, id_stall_o,
        input  rf_wen_o, rf_rd_o, rf_wdata_o, busy_o
    );

    modport slave (
        input  wb_valid_i, wb_rd_i, wb_wdata_i,
        input  md_issue_i, md_issue_rd_i, md_valid_i, md_rd_i, md_wdata_i,
        input  id_rs1_i, id_rs2_i, id_rd_i,
`ifdef RF_SCHED_BYPASS_EN
        output fwd1_valid_o, fwd2_valid_o, fwd_data_o,
`endif
        output wb_stall_o, md_ready_o, id_stall_o,
        output rf_wen_o, rf_rd_o, rf_wdata_o, busy_o
    );
endinterface

// File: rtl/rf_write_sched.sv
// Shares the RF write port between pipeline writeback and mul/div results; scoreboard stalls decode.
// Latency: mul/div write-through 0 cycles, else 1..MAX_WAIT+1 via a one-entry buffer.
// Backpressure: md_ready_o low while buffered; a FORCE cycle stalls writeback for one cycle.
// Optional operand forwarding from the buffer with RF_SCHED_BYPASS_EN.
module rf_write_sched #(
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    rf_write_sched_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, HOLD, FORCE} state_t;

    state_t      state;
    logic [4:0]  buf_rd;
    logic [63:0] buf_dat;
    logic [7:0]  wait_cnt;
    logic [31:0] busy;
    logic [31:0] busy_nxt;

    logic        pipe_wr;
    logic        port_free;
    logic        drain;
    logic        thru;
    logic        clr_vld;
    logic [4:0]  clr_rd;
    logic        force_nxt;

    assign pipe_wr   = bus.wb_valid_i && (bus.wb_rd_i != 5'd0);
    assign port_free = !pipe_wr || (state == FORCE);
    assign drain     = (state == FORCE) || ((state == HOLD) && !pipe_wr);
    assign thru      = (state == IDLE) && bus.md_valid_i && port_free;
    assign clr_vld   = drain || thru;
    assign clr_rd    = drain ? buf_rd : bus.md_rd_i;
    assign force_nxt = ({1'b0, wait_cnt} + 9'd1) >= 9'(MAX_WAIT);

    assign bus.md_ready_o = (state == IDLE);
    assign bus.wb_stall_o = (state == FORCE);
    assign bus.busy_o     = busy;

    // Gated by reset so a held result can never leak out during the reset cycle.
    always_comb begin
        bus.rf_wen_o   = 1'b0;
        bus.rf_rd_o    = 5'd0;
        bus.rf_wdata_o = 64'd0;
        if (!reset) begin
            if (pipe_wr && (state != FORCE)) begin
                bus.rf_wen_o   = 1'b1;
                bus.rf_rd_o    = bus.wb_rd_i;
                bus.rf_wdata_o = bus.wb_wdata_i;
            end else if (drain) begin
                bus.rf_wen_o   = (buf_rd != 5'd0);
                bus.rf_rd_o    = buf_rd;
                bus.rf_wdata_o = buf_dat;
            end else if (thru) begin
                bus.rf_wen_o   = (bus.md_rd_i != 5'd0);
                bus.rf_rd_o    = bus.md_rd_i;
                bus.rf_wdata_o = bus.md_wdata_i;
            end
        end
    end

    // Set applied after clear so a same-cycle issue of a retiring rd stays busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_vld)
            busy_nxt[clr_rd] = 1'b0;
        if (bus.md_issue_i && (bus.md_issue_rd_i != 5'd0))
            busy_nxt[bus.md_issue_rd_i] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            buf_rd   <= 5'd0;
            buf_dat  <= 64'd0;
            wait_cnt <= 8'd0;
            busy     <= 32'd0;
        end else begin
            busy <= busy_nxt;
            case (state)
                IDLE: begin
                    if (bus.md_valid_i && !port_free) begin
                        buf_rd   <= bus.md_rd_i;
                        buf_dat  <= bus.md_wdata_i;
                        wait_cnt <= 8'd1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (!pipe_wr) begin
                        wait_cnt <= 8'd0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (force_nxt)
                            state <= FORCE;
                    end
                end
                FORCE: begin
                    wait_cnt <= 8'd0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RF_SCHED_BYPASS_EN
    logic fwd1;
    logic fwd2;
    assign fwd1 = (state != IDLE) && (buf_rd != 5'd0) && (bus.id_rs1_i == buf_rd);
    assign fwd2 = (state != IDLE) && (buf_rd != 5'd0) && (bus.id_rs2_i == buf_rd);
    assign bus.fwd1_valid_o = fwd1;
    assign bus.fwd2_valid_o = fwd2;
    assign bus.fwd_data_o   = buf_dat;
    assign bus.id_stall_o   = (busy[bus.id_rs1_i] && !fwd1) ||
                              (busy[bus.id_rs2_i] && !fwd2) ||
                              busy[bus.id_rd_i];
`else
    assign bus.id_stall_o = busy[bus.id_rs1_i] | busy[bus.id_rs2_i] | busy[bus.id_rd_i];
`endif
endmodule

// File: doc/rf_write_sched.md
# rf_write_sched

Write-port scheduler and scoreboard for the 32x64 integer register file. It shares the file's single write port between in-order pipeline writeback and the out-of-band multi-cycle mul/div unit. A one-entry holding buffer and a starvation-forcing state machine manage the sharing. It also tracks registers with outstanding mul/div results and stalls decode on RAW/WAW hazards against them.

## Interface
Parameters:
- `MAX_WAIT`, default 4: consecutive blocked cycles for a held mul/div result before pipeline writeback is force-stalled. Legal range is 1..255.

Ports:
- `clock` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `wb_valid_i` in 1: pipeline writeback request.
- `wb_rd_i` in 5: pipeline writeback destination.
- `wb_wdata_i` in 64: pipeline writeback data.
- `wb_stall_o` out 1: pipeline must hold its writeback this cycle.
- `md_issue_i` in 1: decode issues a mul/div op this cycle.
- `md_issue_rd_i` in 5: destination of the issued op.
- `md_valid_i` in 1: mul/div result valid.
- `md_rd_i` in 5: mul/div result destination.
- `md_wdata_i` in 64: mul/div result data.
- `md_ready_o` out 1: mul/div result accepted when high together with `md_valid_i`.
- `id_rs1_i` in 5: decode source 1.
- `id_rs2_i` in 5: decode source 2.
- `id_rd_i` in 5: decode destination.
- `id_stall_o` out 1: hazard stall to decode.
- `rf_wen_o` out 1: register file write enable.
- `rf_rd_o` out 5: register file write address.
- `rf_wdata_o` out 64: register file write data.
- `busy_o` out 32: scoreboard vector; bit i means xi has a pending mul/div write.

## Operation
- "Pipeline write" means `wb_valid_i && wb_rd_i != 0`.
- "Port free" means no pipeline write, or state is `FORCE`.
- FSM states:
  - `IDLE`: buffer empty.
  - `HOLD`: buffer full, waiting for the port.
  - `FORCE`: buffer full, pipeline writeback is blocked.
- In `IDLE`:
  - `md_ready_o` is 1.
  - An accepted result writes through on the same cycle if the port is free.
  - Otherwise the result is captured into the buffer and the FSM goes to `HOLD`, with the wait counter set to 1.
- In `HOLD`:
  - `md_ready_o` is 0.
  - If the port is free, the buffer drains to the register file and the FSM goes to `IDLE`.
  - Otherwise the counter increments. When the counter equals `MAX_WAIT`, the FSM goes to `FORCE`.
- In `FORCE`:
  - `md_ready_o` is 0 and `wb_stall_o` is 1.
  - The buffer drains unconditionally, then the FSM goes to `IDLE`.
  - `wb_stall_o` is 0 in all other states.
- Write-port mux:
  - A pipeline write wins unless the state is `FORCE`.
  - Otherwise a buffer drain or a mul/div write-through drives the port.
  - `rf_wen_o` is 0 when nothing qualifies.
- A mul/div result with rd=0 is accepted and retires normally, but `rf_wen_o` stays 0 for it.
- Scoreboard:
  - On `md_issue_i` with rd≠0, set `busy[md_issue_rd_i]`.
  - When a mul/div result reaches the port, clear `busy[rd]`.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - `busy[0]` is always 0.
- `id_stall_o = busy[id_rs1_i] | busy[id_rs2_i] | busy[id_rd_i]`. This term is combinational.
- Reset, including mid-operation:
  - `busy_o` = 0, buffer invalid, counter 0, FSM in `IDLE`.
  - Outputs: `md_ready_o` = 1, `wb_stall_o` = 0, `id_stall_o` = 0.
  - Write port: `rf_wen_o` = 0, `rf_rd_o` = 0, `rf_wdata_o` = 0.
  - Any held result is discarded.

## Timing
- Write-port outputs are combinational from current inputs and state. The register file captures the write at the next rising edge.
- Mul/div latency to the register file:
  - 0 cycles on write-through.
  - Otherwise 1 to `MAX_WAIT`+1 cycles after acceptance.
- The `busy` clear takes effect at the same edge as the register file write. A dependent decode can therefore proceed in the following cycle.
- `wb_stall_o` is asserted for exactly one cycle per `FORCE` visit. Pipeline writeback must present the same request again in the next cycle.
- `md_ready_o` depends only on state, never combinationally on `md_valid_i`.

## Configuration
- `RF_SCHED_BYPASS_EN` defined:
  - Adds outputs `fwd1_valid_o` (1), `fwd2_valid_o` (1) and `fwd_data_o` (64).
  - `fwdN_valid_o` is 1 when the buffer is full and `id_rsN_i` equals the buffered rd (rd≠0). `fwd_data_o` then carries the buffered data.
  - A forwarded source does not contribute its `busy` term to `id_stall_o`. The `id_rd_i` term still stalls.
- Undefined: no forwarding ports, and `id_stall_o` is as in Operation.

## Test plan
- **Write-through:** idle; `md_valid_i`=1, rd=5, data=0x1234; no pipeline write → same cycle `rf_wen_o`=1, `rf_rd_o`=5, `rf_wdata_o`=0x1234. `busy[5]` clears at that edge.
- **Buffering:** pipeline write x3=0xAA held high continuously, plus a mul/div result for x7=0xBB → cycle 0 writes x3; `md_ready_o` drops. With `MAX_WAIT`=4, `wb_stall_o`=1 in cycle 4 and x7 is written in cycle 4. `md_ready_o`=1 from cycle 5.
- **Hazard:** issue a mul/div op to x9; decode sees rs2=9 → `id_stall_o`=1 until the cycle after x9 is written. The same holds for `id_rd_i`=9.
- **Edge cases:** a result to rd=0 is accepted with `rf_wen_o`=0. Issue and retire of the same rd in one cycle leaves the `busy` bit set.
- **Reset:** reset with the buffer full and `busy_o`=0x0000_0280 → next cycle `busy_o`=0, `md_ready_o`=1, `rf_wen_o`=0, and no write of the held data ever occurs.
- **Bypass (macro on):** buffer holds x7=0xBB, decode rs1=7 → `fwd1_valid_o`=1, `fwd_data_o`=0xBB, and `id_stall_o`=0.
